// File: rtl/muldiv_ctrl_if.sv
// Handshake and result bundle between the E-stage pipeline and the mul/div controller.
interface muldiv_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide sequencer and owner of the HI/LO registers.
// Operands are latched at acceptance; the result is committed after a fixed
// number of busy cycles unless a flush aborts the operation first.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    muldiv_ctrl_if.slave   bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;       // bit0: unsigned, bit1: divide
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [63:0] mul_res;
    logic [63:0] div_res;

    // 32x32 -> 64 product; sign-extending to 64 bits makes one multiplier serve both flavours.
    function automatic logic [63:0] mul64(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = is_unsigned ? {32'd0, a} : {{32{a[31]}}, a};
        eb = is_unsigned ? {32'd0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes so that
    // truncation toward zero and 0x80000000 / -1 fall out without special cases.
    function automatic logic [63:0] div64(input logic is_unsigned,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = !is_unsigned && a[31];
        neg_b = !is_unsigned && b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        if (neg_a ^ neg_b) q = 32'd0 - q;
        if (neg_a)         r = 32'd0 - r;
        return {r, q};
    endfunction

    // Result datapath, evaluated from the latched operands.
    always_comb begin
        mul_res = mul64(op_q[0], a_q, b_q);
        div_res = div64(op_q[0], a_q, b_q);
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    if (!bus.op[2]) begin
                        op_d    = bus.op[1:0];
                        a_d     = bus.src_a;
                        b_d     = bus.src_b;
                        cnt_d   = bus.op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.src_a;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.src_a;
                    end
                end
            end
            RUN: begin
                if (bus.flush) begin
                    // Abort: drop the operation, HI/LO untouched, no done pulse.
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 4'd0;
                    if (!op_q[1]) begin
                        hi_d = mul_res[63:32];
                        lo_d = mul_res[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = div_res[63:32];
                        lo_d = div_res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 2'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
